inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the decode/execute FSM of the multicycle MIPS core.
//  Drives the instruction memory address, waits out memory fill, and captures the
//  synchronous read data into a small prefetch FIFO tagged with its PC.
//  Presents one instruction at a time to the consumer over a valid/ready handshake.
//  Accepts branch/jump redirects by flushing the FIFO and any in-flight read.
// PARAMETERS
//  PC_W      16  width of PC and memory byte address
//  DEPTH     2   prefetch FIFO entries; power of two, >=2
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk          in   1     core clock
//  rst          in   1     asynchronous reset, active-high
//  mem_busy     in   1     high while instruction memory is filling; no reads allowed
//  imem_addr    out  PC_W  instruction memory byte address; low 2 bits always 0
//  imem_q       in   32    read data; valid the cycle after imem_addr was presented
//  redirect     in   1     one-cycle pulse: discard buffered work, fetch from redirect_pc
//  redirect_pc  in   PC_W  new fetch PC; bits [1:0] forced to 0
//  inst         out  32    head instruction word
//  inst_pc      out  PC_W  PC of inst
//  inst_valid   out  1     inst/inst_pc valid
//  inst_ready   in   1     consumer takes head when inst_valid & inst_ready
//  halted       out  1     HALT opcode fetched (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=WAIT_MEM, fetch_pc=RESET_PC, FIFO empty, no in-flight read,
//    inst_valid=0, inst=0, inst_pc=0, halted=0; imem_addr=fetch_pc combinationally.
//  States:
//  - WAIT_MEM: no reads issued; go to RUN on first edge with mem_busy=0.
//  - RUN: normal fetching.
//  - HALT: entered only when the HALT feature is compiled in; see CONFIGURATION.
//  Issue (RUN only): issue a read when count+inflight<DEPTH, or when a pop occurs
//    this cycle. On issue, inflight_pc<=fetch_pc and fetch_pc<=fetch_pc+4.
//  - fetch_pc arithmetic is modulo 2^PC_W: 0xFFFC+4 wraps to 0x0000.
//  Response: the cycle after issue, {imem_q, inflight_pc} is pushed into the FIFO.
//  Latency: the first read is issued in the first RUN cycle; inst_valid rises 2 edges
//    after entering RUN. Sustained throughput is 1 instruction/cycle with inst_ready=1.
//  Handshake: inst/inst_pc stay stable while inst_valid=1 and inst_ready=0. The FIFO
//    never overflows and never drops a word.
//  Push and pop in the same cycle are both performed; count is unchanged.
//  Redirect has priority over issue, push and pop in the same cycle:
//  - FIFO flushed, in-flight response discarded, fetch_pc<=redirect_pc.
//  - inst_valid=0 on the next cycle.
//  - The redirect_pc read is issued in the cycle after redirect.
//  mem_busy rising while in RUN:
//  - Flush FIFO, discard the in-flight read, go to WAIT_MEM.
//  - fetch_pc<= oldest undelivered PC: FIFO head PC, else inflight_pc, else fetch_pc.
//  - Fetching resumes from that PC when mem_busy falls.
//  Redirect while in WAIT_MEM only updates fetch_pc.
// CONFIGURATION
//  FETCH_HALT_DETECT_EN defined:
//  - A pushed word with opcode [31:26]=6'b111111 is still delivered.
//  - After that push the state becomes HALT: halted=1, no further reads, and any
//    response in flight is discarded.
//  - Remaining FIFO entries still drain to the consumer.
//  - redirect clears halted and returns to RUN; rst also leaves HALT.
//  FETCH_HALT_DETECT_EN undefined: opcode 6'b111111 is an ordinary word; halted tied 0.
// TESTING
//  1 mem_busy=1 for 5 cycles after reset -> imem_addr=0x0000, inst_valid=0; after fall
//    inst_valid=1 two edges after RUN entry with inst_pc=0x0000.
//  2 inst_ready=1 continuously -> inst_pc 0x0,0x4,0x8,0xC on consecutive cycles;
//    inst equals the memory contents at those addresses.
//  3 inst_ready=0 for 10 cycles mid-stream -> inst held stable, count=DEPTH, no read
//    issued; after release the PCs continue contiguously with no gaps or duplicates.
//  4 redirect to 0x0040 with full FIFO and a read in flight -> next valid inst_pc=0x0040;
//    no stale PC appears after it.
//  5 redirect to 0xFFFC -> delivered inst_pc sequence is 0xFFFC, 0x0000, 0x0004.
//  6 word 0xFC000000 at 0x0008:
//    - macro defined -> delivered, halted=1, no inst_pc 0x000C ever appears.
//    - macro undefined -> halted=0 and 0x000C follows.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage of the multicycle MIPS core.
// Latency: first word valid 2 edges after entering RUN, then 1 instruction/cycle.
// Backpressure: inst_ready=0 holds the head word; reads stop once FIFO + in-flight reach DEPTH.
//
// Ports:
//   clk, rst              core clock, asynchronous active-high reset
//   mem_busy              instruction memory filling; no reads while high
//   imem_addr / imem_q    word-aligned read address / read data (valid one cycle later)
//   redirect/redirect_pc  branch/jump: flush buffered work, fetch from redirect_pc
//   inst/inst_pc/inst_valid/inst_ready   head-of-FIFO instruction handshake
//   halted                HALT opcode fetched
// Optional feature: define FETCH_HALT_DETECT_EN to stop fetching after a word with
// opcode 6'b111111 (the word itself is still delivered). Undefined: halted is tied 0.
module inst_fetch_unit #(
    parameter int PC_W     = 16,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_busy,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_q,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic            halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PC_W-1:0]  ALIGN_MASK = ~PC_W'(3);
    localparam logic [PC_W-1:0]  RESET_PC_A = PC_W'(RESET_PC) & ALIGN_MASK;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_WAIT_MEM = 2'd0,
        S_RUN      = 2'd1,
        S_HALT     = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Fetch pointer and the single outstanding read (issued last cycle, data on imem_q now).
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            infl_vld_q, infl_vld_d;
    logic [PC_W-1:0] infl_pc_q, infl_pc_d;

    // Prefetch FIFO: word + PC per entry.
    logic [31:0]     fifo_inst_q [DEPTH];
    logic [31:0]     fifo_inst_d [DEPTH];
    logic [PC_W-1:0] fifo_pc_q   [DEPTH];
    logic [PC_W-1:0] fifo_pc_d   [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             run;
    logic             pop;
    logic             push;
    logic             halt_hit;
    logic             halt_push;
    logic             issue;
    logic             busy_flush;
    logic [CNT_W-1:0] occ;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PC_W-1:0]  resume_pc;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit = (imem_q[31:26] == 6'b111111);
`else
    assign halt_hit = 1'b0;
`endif

    assign run = (state_q == S_RUN);
    assign pop = inst_valid & inst_ready;

    // The response is pushed unless this cycle flushes (redirect or memory going busy).
    assign push      = run & infl_vld_q & ~mem_busy & ~redirect;
    assign halt_push = push & halt_hit;

    // count + in-flight never exceeds DEPTH; a pop this cycle frees the slot the new read needs.
    assign occ   = count_q + {{(CNT_W-1){1'b0}}, infl_vld_q};
    assign issue = run & ~mem_busy & ~redirect & ~halt_push & ((occ < DEPTH_C) | pop);

    assign busy_flush = run & mem_busy;

    // Oldest PC not yet handed to the consumer; a pop in the flush cycle still counts as
    // delivered, so the entry behind the head becomes the oldest.
    always_comb begin
        rd_ptr_nxt = rd_ptr_q + 1'b1;
        resume_pc  = fetch_pc_q;
        if (pop && (count_q > CNT_W'(1))) begin
            resume_pc = fifo_pc_q[rd_ptr_nxt];
        end else if (!pop && (count_q != '0)) begin
            resume_pc = fifo_pc_q[rd_ptr_q];
        end else if (infl_vld_q) begin
            resume_pc = infl_pc_q;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT_MEM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_MEM: begin
                if (!mem_busy) state_d = S_RUN;
            end
            S_RUN: begin
                if (mem_busy)       state_d = S_WAIT_MEM;
                else if (halt_push) state_d = S_HALT;
            end
            S_HALT: begin
                if (redirect) state_d = mem_busy ? S_WAIT_MEM : S_RUN;
            end
            default: state_d = S_WAIT_MEM;
        endcase
    end

    always_comb begin
        imem_addr  = fetch_pc_q;
        inst_valid = (count_q != '0);
        inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : 32'd0;
        inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;
`ifdef FETCH_HALT_DETECT_EN
        halted     = (state_q == S_HALT);
`else
        halted     = 1'b0;
`endif
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        infl_vld_d  = 1'b0;
        infl_pc_d   = infl_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fifo_inst_d = fifo_inst_q;
        fifo_pc_d   = fifo_pc_q;

        if (redirect) begin
            // Wins over everything; in WAIT_MEM the FIFO is already empty, so only the PC moves.
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else if (busy_flush) begin
            fetch_pc_d = resume_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                infl_vld_d = 1'b1;
                infl_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + PC_W'(4);
            end
            if (push) begin
                fifo_inst_d[wr_ptr_q] = imem_q;
                fifo_pc_d[wr_ptr_q]   = infl_pc_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC_A;
            infl_vld_q <= 1'b0;
            infl_pc_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            infl_vld_q  <= infl_vld_d;
            infl_pc_q   <= infl_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_pc_q   <= fifo_pc_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized bench for inst_fetch_unit against a stream-level model.
// The model only knows "the next delivered PC" (contiguous from the last redirect) and
// the memory contents; directed phases check latency, stalls, redirects and HALT.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_busy;
    logic [15:0] imem_addr;
    logic [31:0] imem_q = 32'd0;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        halted;

    logic [31:0] mem [16384];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] exp_pc;
    bit          halt_seen;
    bit          seen_c;
    bit          prev_hold;
    logic [31:0] prev_inst;
    logic [15:0] prev_pc;
    int          busy_left;

    inst_fetch_unit #(.PC_W(16), .DEPTH(2), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_busy    (mem_busy),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) imem_q <= mem[imem_addr[15:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: observe at negedge (inputs stable), apply the model, return #1 after posedge.
    task automatic tick();
        bit fire;
        @(negedge clk);
        chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (prev_hold) begin
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_inst", inst, prev_inst);
            chk("hold_pc", 32'(inst_pc), 32'(prev_pc));
        end
        fire = inst_valid && inst_ready && !redirect;
        if (fire) begin
            chk("after_halt", 32'(halt_seen), 32'd0);
            chk("deliver_pc", 32'(inst_pc), 32'(exp_pc));
            chk("deliver_inst", inst, mem[exp_pc[15:2]]);
            if (inst_pc == 16'h000C) seen_c = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
            if (mem[exp_pc[15:2]][31:26] == 6'b111111) halt_seen = 1'b1;
`endif
            exp_pc = exp_pc + 16'd4;
        end
        if (redirect) begin
            exp_pc    = redirect_pc & 16'hFFFC;
            halt_seen = 1'b0;
        end
        prev_hold = inst_valid && !inst_ready && !redirect && !mem_busy;
        prev_inst = inst;
        prev_pc   = inst_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 10 && !inst_valid; n++) tick();
        chk(tag, 32'(inst_valid), 32'd1);
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i] = $urandom;
            if (mem[i][31:26] == 6'b111111) mem[i][31] = 1'b0;
        end
        rst = 1'b1; mem_busy = 1'b1; redirect = 1'b0; redirect_pc = 16'd0; inst_ready = 1'b0;
        exp_pc = 16'd0; halt_seen = 1'b0; seen_c = 1'b0; prev_hold = 1'b0; busy_left = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", 32'(inst_pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);

        // 1: memory busy, then first-fetch latency
        repeat (5) tick();
        chk("busy_addr", 32'(imem_addr), 32'd0);
        chk("busy_valid", 32'(inst_valid), 32'd0);
        mem_busy = 1'b0; inst_ready = 1'b1;
        tick(); chk("lat_e1", 32'(inst_valid), 32'd0);
        tick(); chk("lat_e2", 32'(inst_valid), 32'd0);
        tick(); chk("lat_e3", 32'(inst_valid), 32'd1);
        chk("first_pc", 32'(inst_pc), 32'd0);

        // 2: one instruction per cycle
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("stream_valid", 32'(inst_valid), 32'd1);
            chk("stream_pc", 32'(inst_pc), 32'(4 * k));
        end

        // 3: stall with head 0xC; FIFO holds 0xC,0x10 so the next fetch stays at 0x14
        inst_ready = 1'b0;
        repeat (10) tick();
        chk("stall_addr", 32'(imem_addr), 32'h14);
        chk("stall_pc", 32'(inst_pc), 32'hC);
        chk("stall_inst", inst, mem[3]);
        for (int k = 0; k < 40; k++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // 4: redirect with full FIFO, then with a read in flight
        inst_ready = 1'b0;
        repeat (3) tick();
        do_redirect(16'h0040);
        chk("redir_valid", 32'(inst_valid), 32'd0);
        inst_ready = 1'b1;
        wait_valid("redir_wait");
        chk("redir_pc", 32'(inst_pc), 32'h40);
        repeat (6) tick();
        do_redirect(16'h0080);
        chk("redir2_valid", 32'(inst_valid), 32'd0);
        wait_valid("redir2_wait");
        chk("redir2_pc", 32'(inst_pc), 32'h80);
        repeat (4) tick();

        // 5: wrap-around from 0xFFFC (low bits of redirect_pc ignored)
        do_redirect(16'hFFFF);
        wait_valid("wrap_wait");
        chk("wrap_pc0", 32'(inst_pc), 32'hFFFC);
        tick(); chk("wrap_pc1", 32'(inst_pc), 32'h0000);
        tick(); chk("wrap_pc2", 32'(inst_pc), 32'h0004);
        repeat (3) tick();

        // 6: HALT opcode at 0x0008
        mem[2] = 32'hFC000000;
        do_redirect(16'h0000);
        seen_c = 1'b0;
        repeat (15) tick();
`ifdef FETCH_HALT_DETECT_EN
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_no_c", 32'(seen_c), 32'd0);
        chk("halt_drained", 32'(inst_valid), 32'd0);
`else
        chk("halt_flag", 32'(halted), 32'd0);
        chk("halt_c_seen", 32'(seen_c), 32'd1);
`endif
        mem[2] = $urandom & 32'h7FFFFFFF;
        do_redirect(16'h0100);
        chk("halt_clear", 32'(halted), 32'd0);

        // 7: random ready / redirect / memory-busy traffic
        for (int k = 0; k < 500; k++) begin
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = 16'($urandom);
            if (busy_left > 0) begin
                mem_busy = 1'b1;
                busy_left--;
            end else begin
                mem_busy = 1'b0;
                if ($urandom_range(0, 29) == 0) busy_left = $urandom_range(1, 6);
            end
            tick();
        end
        redirect = 1'b0; mem_busy = 1'b0; inst_ready = 1'b1;
        repeat (10) tick();
        chk("final_valid", 32'(inst_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
